// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one interconnect master port.
// Optional lock feature: define ARB_LOCK_EN to let an owner keep priority.
module bus_arbiter #(
    parameter int WIDTH        = 32,
    parameter int NUM_MASTERS  = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_MASTERS-1:0]       m_req,
    input  logic [NUM_MASTERS-1:0]       m_we,
    input  logic [NUM_MASTERS*WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*WIDTH-1:0] m_wd,
    input  logic [NUM_MASTERS-1:0]       m_lock,
    output logic [NUM_MASTERS-1:0]       m_gnt,
    output logic [NUM_MASTERS-1:0]       m_ack,
    output logic [WIDTH-1:0]             m_rd,
    output logic                         busy,
    output logic                         we_m,
    output logic [WIDTH-1:0]             addr_m,
    output logic [WIDTH-1:0]             wd_m,
    input  logic [WIDTH-1:0]             rd_m
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wd_q, wd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              win_valid;
    logic [PW-1:0]     win_idx;
    logic              sel_we;
    logic [WIDTH-1:0]  sel_addr;
    logic [WIDTH-1:0]  sel_wd;
    logic [PW-1:0]     ptr_next;

`ifndef ARB_LOCK_EN
    logic              lock_unused;
    assign lock_unused = ^m_lock;
`endif

    // Rotating-priority search starting at ptr, picks winner and its inputs
    always_comb begin
        int            s;
        logic [PW-1:0] idx;
        win_valid = 1'b0;
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wd    = '0;
        s         = 0;
        idx       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_MASTERS) begin
                s = s - NUM_MASTERS;
            end
            idx = PW'(s);
            if (!win_valid && m_req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
                sel_we    = m_we[idx];
                sel_addr  = m_addr[s*WIDTH +: WIDTH];
                sel_wd    = m_wd[s*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advance after a completed transaction, wrapping N-1 -> 0
    always_comb begin
        if (owner_q == LAST_IDX) begin
            ptr_next = '0;
        end else begin
            ptr_next = owner_q + PW'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: grant latch, latency countdown, pointer update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_ISSUE;
                    owner_d = win_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wd_d    = sel_wd;
                    rdata_d = '0;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = rd_m;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef ARB_LOCK_EN
                if (m_lock[owner_q]) begin
                    ptr_d = owner_q;
                end else begin
                    ptr_d = ptr_next;
                end
`else
                ptr_d = ptr_next;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode per state; grant is suppressed while reset is held
    always_comb begin
        m_gnt  = '0;
        m_ack  = '0;
        m_rd   = '0;
        we_m   = 1'b0;
        addr_m = '0;
        wd_m   = '0;
        busy   = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (win_valid && rst_n) begin
                    m_gnt[win_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                we_m   = we_q;
                addr_m = addr_q;
                wd_m   = wd_q;
            end
            S_WAIT: begin
                addr_m = addr_q;
            end
            S_RESP: begin
                m_ack[owner_q] = 1'b1;
                m_rd           = rdata_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter, N=3, READ_LATENCY=2.
// Expected acks are queued at grant time and matched when m_ack fires.
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int RL = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   m_req;
    logic [N-1:0]   m_we;
    logic [N*W-1:0] m_addr;
    logic [N*W-1:0] m_wd;
    logic [N-1:0]   m_lock;
    logic [N-1:0]   m_gnt;
    logic [N-1:0]   m_ack;
    logic [W-1:0]   m_rd;
    logic           busy;
    logic           we_m;
    logic [W-1:0]   addr_m;
    logic [W-1:0]   wd_m;
    logic [W-1:0]   rd_m;

    bus_arbiter #(
        .WIDTH        (W),
        .NUM_MASTERS  (N),
        .READ_LATENCY (RL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wd   (m_wd),
        .m_lock (m_lock),
        .m_gnt  (m_gnt),
        .m_ack  (m_ack),
        .m_rd   (m_rd),
        .busy   (busy),
        .we_m   (we_m),
        .addr_m (addr_m),
        .wd_m   (wd_m),
        .rd_m   (rd_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data is only valid RL cycles after the address appears
    function automatic logic [W-1:0] memf(input logic [W-1:0] a);
        if (a == 32'h200) return 32'h1234_5678;
        return (a * 3) + 32'h0000_1000;
    endfunction

    logic [W-1:0] last_a;
    int           prev_run;
    int           run;

    always_comb begin
        run = 0;
        if (addr_m != '0 && addr_m == last_a) run = prev_run + 1;
    end

    assign rd_m = (run == RL) ? memf(addr_m) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        last_a   <= addr_m;
        prev_run <= run;
    end

    typedef struct {
        int           who;
        int           due;
        logic [W-1:0] rd;
    } exp_t;

    exp_t         sb[$];
    int           gnt_log[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;

    logic [N-1:0] req_v;
    logic [N-1:0] we_v;
    logic [N-1:0] lock_v;
    logic [N-1:0] one_shot;
    logic [W-1:0] addr_v[N];
    logic [W-1:0] wd_v[N];

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   g;
        if (m_gnt !== '0) begin
            chk("gnt_onehot", W'($onehot(m_gnt)), 1);
            g = 0;
            for (int i = 0; i < N; i++) if (m_gnt[i]) g = i;
            gnt_log.push_back(g);
            e.who = g;
            e.due = cyc + (m_we[g] ? 2 : 2 + RL);
            e.rd  = m_we[g] ? '0 : memf(m_addr[g*W +: W]);
            sb.push_back(e);
            if (one_shot[g]) req_v[g] = 1'b0;
        end
        if (m_ack !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", W'(m_ack), 0);
            end else begin
                e = sb.pop_front();
                chk("ack_who", W'(m_ack), W'(1) << e.who);
                chk("ack_cycle", cyc, e.due);
                chk("ack_rdata", m_rd, e.rd);
            end
        end else begin
            chk("m_rd_quiet", m_rd, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_req  = req_v;
        m_we   = we_v;
        m_lock = lock_v;
        for (int i = 0; i < N; i++) begin
            m_addr[i*W +: W] = addr_v[i];
            m_wd[i*W +: W]   = wd_v[i];
        end
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic req_once(input int i, input logic we,
                            input logic [W-1:0] a, input logic [W-1:0] d);
        req_v[i]    = 1'b1;
        one_shot[i] = 1'b1;
        we_v[i]     = we;
        addr_v[i]   = a;
        wd_v[i]     = d;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int target;
        int k;
        target = gnt_log.size() + n;
        k      = 0;
        while (gnt_log.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (gnt_log.size() < target) chk("grant_timeout", gnt_log.size(), target);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        tick();
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", W'(busy), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, W'(busy), 0);
        chk({tag, "_gnt"}, W'(m_gnt), 0);
        chk({tag, "_ack"}, W'(m_ack), 0);
        chk({tag, "_we"}, W'(we_m), 0);
        chk({tag, "_addr"}, addr_m, 0);
        chk({tag, "_wd"}, wd_m, 0);
        chk({tag, "_rd"}, m_rd, 0);
    endtask

    initial begin
        int g;
        int base;
        int exp_ord[4];

        rst_n    = 1'b0;
        req_v    = 3'b111;
        we_v     = '0;
        lock_v   = '0;
        one_shot = '0;
        m_req    = '0;
        m_we     = '0;
        m_lock   = '0;
        m_addr   = '0;
        m_wd     = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = 32'h10 + i;
            wd_v[i]   = '0;
        end

        // Reset state, requests present but held off
        repeat (3) tick();
        chk_quiet("reset");
        req_v = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single write from m0
        req_once(0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        wait_grants(1, 10);
        g = cyc;
        chk("t2_gnt_who", gnt_log[gnt_log.size()-1], 0);
        tick();
        chk("t2_we_m", W'(we_m), 1);
        chk("t2_addr_m", addr_m, 32'h100);
        chk("t2_wd_m", wd_m, 32'hDEAD_BEEF);
        tick();
        chk("t2_ack", W'(m_ack), 3'b001);
        chk("t2_ack_cyc", cyc, g + 2);
        tick();
        chk("t2_idle", W'(busy), 0);

        // Reset in the middle of a read wait
        req_once(1, 1'b0, 32'h300, 32'h0);
        wait_grants(1, 10);
        chk("t1_gnt_who", gnt_log[gnt_log.size()-1], 1);
        tick();
        tick();
        chk("t1_in_wait", W'(busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("t1_async");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t1_no_ack_busy", W'(busy), 0);

        // Contention from reset: m0 write, m1 read, held continuously
        base      = gnt_log.size();
        one_shot  = '0;
        we_v      = 3'b001;
        addr_v[0] = 32'h400;
        wd_v[0]   = 32'hA5A5_0000;
        addr_v[1] = 32'h404;
        wd_v[1]   = '0;
        req_v     = 3'b011;
        wait_grants(4, 60);
        req_v = '0;
        drain();
        exp_ord = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_order%0d", i), gnt_log[base+i], exp_ord[i]);
        end

        // Single read from m1, latency 2
        req_once(1, 1'b0, 32'h200, 32'h0);
        wait_grants(1, 10);
        g = cyc;
        tick();
        chk("t3_addr_c1", addr_m, 32'h200);
        chk("t3_we_c1", W'(we_m), 0);
        tick();
        chk("t3_addr_c2", addr_m, 32'h200);
        chk("t3_wd_c2", wd_m, 0);
        tick();
        chk("t3_addr_c3", addr_m, 32'h200);
        chk("t3_no_ack_c3", W'(m_ack), 0);
        tick();
        chk("t3_ack", W'(m_ack), 3'b010);
        chk("t3_rdata", m_rd, 32'h1234_5678);
        chk("t3_ack_cyc", cyc, g + 4);
        chk("t3_addr_resp", addr_m, 0);
        drain();

        // Pointer wrap: m2 alone, then m0 and m2 together
        base = gnt_log.size();
        req_once(2, 1'b1, 32'h500, 32'h55);
        wait_grants(1, 10);
        req_once(0, 1'b1, 32'h504, 32'h66);
        req_once(2, 1'b0, 32'h508, 32'h0);
        wait_grants(2, 30);
        drain();
        chk("t5_first", gnt_log[base], 2);
        chk("t5_wrap", gnt_log[base+1], 0);
        chk("t5_third", gnt_log[base+2], 2);

        // Lock held by m0, then dropped
        base      = gnt_log.size();
        one_shot  = '0;
        we_v      = 3'b011;
        addr_v[0] = 32'h600;
        addr_v[1] = 32'h604;
        lock_v    = 3'b001;
        req_v     = 3'b011;
        wait_grants(3, 40);
        lock_v = '0;
        wait_grants(1, 20);
        req_v = '0;
        drain();
`ifdef ARB_LOCK_EN
        exp_ord = '{0, 0, 0, 1};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_order%0d", i), gnt_log[base+i], exp_ord[i]);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
